ws2812_strip_driver: RTL and testbench
======================================

# ws2812_strip_driver

Parametrised WS2812/WS2812B serial LED driver for strips and matrices of `LED_NUM` pixels. It sits between a pixel source (frame buffer reader, pattern generator) and the single-wire LED data pin. It accepts one 24-bit pixel per valid/ready handshake and serialises it MSB first with NRZ pulse-width timing derived from `CLK_FRE`. After the last pixel it holds the line low for the latch/reset period and then signals frame completion.

## Interface
- `CLK_FRE`, 27_000_000, clock frequency in Hz
- `LED_NUM`, 8, pixels per frame (≥1)
- `T0H_NS`, 400, "0" high time in ns
- `T0L_NS`, 850, "0" low time in ns
- `T1H_NS`, 850, "1" high time in ns
- `T1L_NS`, 400, "1" low time in ns
- `RESET_US`, 80, latch low time in µs (≥50)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  single-cycle frame request; sampled only in IDLE
- `pix_data`  in  24  pixel in wire order {G,R,B}; bit 23 is sent first
- `pix_valid`  in  1  `pix_data` is valid
- `pix_ready`  out  1  driver accepts a pixel this cycle (registered)
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_done`  out  1  one-cycle pulse on completion of a full frame
- `underrun`  out  1  one-cycle pulse on pixel-starvation abort
- `dout`  out  1  WS2812 data line (registered)

## Operation
- Cycle counts are integer-truncated: `CxY = (CLK_FRE/1000)*Tx_NS/1_000_000`, and `CRST = (CLK_FRE/1_000_000)*RESET_US`. With the defaults: C0H=10, C0L=22, C1H=22, C1L=10, CRST=2160. All counts must be ≥1; elaboration fails otherwise.
- States: IDLE, LOAD, BIT_HIGH, BIT_LOW, LATCH.
- IDLE: `dout`=0. `start`=1 → LOAD, and the pixel counter clears. `start` in any other state is ignored.
- LOAD: `pix_ready`=1 and `dout`=0. On `pix_valid`&&`pix_ready`, the driver captures `pix_data` into the shift register, loads bit counter = 23, and goes to BIT_HIGH. Without `pix_valid` it waits.
- BIT_HIGH: `dout`=1 for C1H or C0H cycles, selected by the current bit, then BIT_LOW.
- BIT_LOW: `dout`=0 for C1L or C0L cycles. At the end of the phase:
  - bit counter > 0: shift, decrement, go to BIT_HIGH.
  - bit counter = 0 and pixel counter < LED_NUM−1: increment the pixel counter, go to LOAD.
  - otherwise: go to LATCH.
- LATCH: `dout`=0 for CRST cycles, then IDLE with `frame_done`←1.
- Counter widths: timing counter `$clog2(max count+1)`; pixel counter `$clog2(LED_NUM+1)`; bit counter 5 bits. There is no wrap inside a frame.

## Timing
- Reset values (asynchronous, immediate): `dout`=0, `pix_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0, state IDLE. Reset mid-bit forces `dout` low at once. The next `start` begins a fresh frame at pixel 0.
- `start` sampled at edge N → `pix_ready`=1 and `busy`=1 from cycle N+1.
- Handshake at edge H → `pix_ready`=0 and `dout`=1 from cycle H+1.
- Bit period is exactly CxH+CxL cycles. Bits within a pixel have no gap.
- Inter-pixel gap: the last bit's low phase is extended by LOAD dwell, minimum 1 cycle (37 ns at 27 MHz).
- At the end of LATCH, the cycle after the terminal count has `busy`=0 and `frame_done`=1. A `start` in that same cycle is accepted.
- `pix_data` is only sampled on the handshake edge. Holding `pix_valid` high between frames has no effect.

## Configuration
- `WS2812_UNDERRUN_EN` defined: a LOAD wait counter runs for pixel index ≥1. If `CRST/2` cycles elapse without a handshake, the frame aborts:
  - `underrun` pulses one cycle, on the same edge LOAD→LATCH.
  - LATCH runs in full, then the driver returns to IDLE.
  - `frame_done` stays 0 for that frame.
- Not defined: LOAD waits indefinitely and `underrun` is tied to 0. Starvation beyond ~50 µs causes the LEDs to latch a partial frame; the source is responsible for avoiding it.

## Test plan
- Reset: `rst_n`=0 mid-BIT_HIGH → `dout`, `busy`, `pix_ready`, `frame_done`, `underrun` all 0 immediately. After release, `start` with pixel 24'h000000 → first `dout` high lasts 10 cycles.
- Single frame, LED_NUM=2, pixels 24'hA50FC3 and 24'h800001 with `pix_valid` always high:
  - 48 pulses MSB first; high widths of 22 cycles ("1") or 10 cycles ("0").
  - Each bit period is 32 cycles; the inter-pixel gap is 1 cycle.
- Back-pressure: `pix_valid` for pixel 2 held low 5 cycles after `pix_ready` rises → `dout` low for those 5 extra cycles, no glitch, pixel 2 bits correct.
- Latch/done: after the last bit's low phase, `dout`=0 for 2160 cycles, then `frame_done`=1 for exactly 1 cycle with `busy`=0. A `start` pulsed mid-frame is ignored, and no second frame follows.
- Underrun, `WS2812_UNDERRUN_EN` defined: pixel 2 withheld 1080 cycles → `underrun` pulse, 2160-cycle latch, `frame_done` never asserted.
- Same stimulus with the macro undefined: the driver waits, and completes normally once pixel 2 is supplied.

Source files
------------

// File: rtl/ws2812_strip_driver_if.sv
// -----------------------------------------------------------------------------
// ws2812_strip_driver_if
// Pixel stream handshake between a pixel source and ws2812_strip_driver.
//   pix_data  [23:0] pixel in wire order {G,R,B}, bit 23 is sent first
//   pix_valid        source has a pixel on pix_data
//   pix_ready        driver accepts a pixel this cycle
// Modports: master = pixel source, slave = LED driver.
// -----------------------------------------------------------------------------
interface ws2812_strip_driver_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (
      output pix_data,
      output pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/ws2812_strip_driver.sv
// -----------------------------------------------------------------------------
// ws2812_strip_driver
// Serialises LED_NUM 24-bit pixels onto a single WS2812 data line using NRZ
// pulse-width coding (MSB first), then holds the line low for the latch period
// and pulses frame_done.
//
// Ports:
//   clk         system clock (CLK_FRE Hz)
//   rst_n       asynchronous active-low reset
//   start       one-cycle frame request, only honoured while idle
//   pix_if      slave side of the pixel handshake (pix_data/pix_valid/pix_ready)
//   busy        frame in progress
//   frame_done  one-cycle pulse after the latch period of a complete frame
//   underrun    one-cycle pulse when a frame is aborted for lack of pixels
//   dout        WS2812 data line
//
// Optional feature macro: WS2812_UNDERRUN_EN
//   Defined: while waiting for pixel index >= 1, CRST/2 cycles without a
//   handshake abort the frame (underrun pulse, full latch, no frame_done).
//   Undefined: the driver waits indefinitely and underrun stays 0.
// -----------------------------------------------------------------------------
module ws2812_strip_driver #(
   parameter int CLK_FRE  = 27_000_000,
   parameter int LED_NUM  = 8,
   parameter int T0H_NS   = 400,
   parameter int T0L_NS   = 850,
   parameter int T1H_NS   = 850,
   parameter int T1L_NS   = 400,
   parameter int RESET_US = 80
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   ws2812_strip_driver_if.slave        pix_if,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        underrun,
   output logic                        dout
);

   // Phase lengths in clock cycles (integer truncation).
   localparam int C0H  = (CLK_FRE / 1000) * T0H_NS / 1_000_000;
   localparam int C0L  = (CLK_FRE / 1000) * T0L_NS / 1_000_000;
   localparam int C1H  = (CLK_FRE / 1000) * T1H_NS / 1_000_000;
   localparam int C1L  = (CLK_FRE / 1000) * T1L_NS / 1_000_000;
   localparam int CRST = (CLK_FRE / 1_000_000) * RESET_US;

   localparam int CM_A = (C0H > C0L) ? C0H : C0L;
   localparam int CM_B = (C1H > C1L) ? C1H : C1L;
   localparam int CM_C = (CM_A > CM_B) ? CM_A : CM_B;
   localparam int CMAX = (CM_C > CRST) ? CM_C : CRST;

   localparam int TW = $clog2(CMAX + 1);
   localparam int PW = $clog2(LED_NUM + 1);

   // Terminal counts: a phase of N cycles ends when the counter reads N-1.
   localparam logic [TW-1:0] T0H_END  = TW'(C0H - 1);
   localparam logic [TW-1:0] T0L_END  = TW'(C0L - 1);
   localparam logic [TW-1:0] T1H_END  = TW'(C1H - 1);
   localparam logic [TW-1:0] T1L_END  = TW'(C1L - 1);
   localparam logic [TW-1:0] RST_END  = TW'(CRST - 1);
   localparam logic [PW-1:0] LAST_PIX = PW'(LED_NUM - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_HIGH  = 3'd2;
   localparam logic [2:0] S_LOW   = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   if ((LED_NUM < 1) || (C0H < 1) || (C0L < 1) || (C1H < 1) || (C1L < 1) || (CRST < 2))
   begin : g_bad_cfg
      $error("ws2812_strip_driver: LED_NUM or a derived cycle count is out of range");
   end

   logic [2:0]    state_q,      state_d;
   logic [TW-1:0] tcnt_q,       tcnt_d;
   logic [23:0]   shift_q,      shift_d;
   logic [4:0]    bit_q,        bit_d;
   logic [PW-1:0] pix_q,        pix_d;
   logic          abort_q,      abort_d;
   logic          dout_q,       dout_d;
   logic          pix_ready_q,  pix_ready_d;
   logic          busy_q,       busy_d;
   logic          frame_done_q, frame_done_d;
   logic          underrun_q,   underrun_d;

   logic [TW-1:0] high_end_s;
   logic [TW-1:0] low_end_s;
   logic          handshake_s;
   logic          timeout_s;

   // Phase lengths follow the bit currently at the head of the shift register.
   assign high_end_s  = shift_q[23] ? T1H_END : T0H_END;
   assign low_end_s   = shift_q[23] ? T1L_END : T0L_END;
   assign handshake_s = pix_if.pix_valid & pix_ready_q;

`ifdef WS2812_UNDERRUN_EN
   localparam logic [TW-1:0] UR_END = TW'(CRST / 2 - 1);
   // The LOAD dwell counter only arms from the second pixel on.
   assign timeout_s = (pix_q != {PW{1'b0}}) && (tcnt_q == UR_END);
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state, counter and output decode for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      tcnt_d       = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
      shift_d      = shift_q;
      bit_d        = bit_q;
      pix_d        = pix_q;
      abort_d      = abort_q;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            tcnt_d = {TW{1'b0}};
            if (start) begin
               state_d = S_LOAD;
               pix_d   = {PW{1'b0}};
               abort_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (handshake_s) begin
               shift_d = pix_if.pix_data;
               bit_d   = 5'd23;
               tcnt_d  = {TW{1'b0}};
               state_d = S_HIGH;
            end else if (timeout_s) begin
               tcnt_d     = {TW{1'b0}};
               underrun_d = 1'b1;
               abort_d    = 1'b1;
               state_d    = S_LATCH;
            end else begin
`ifdef WS2812_UNDERRUN_EN
               if (pix_q == {PW{1'b0}}) begin
                  tcnt_d = {TW{1'b0}};
               end else begin
                  tcnt_d = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
               end
`else
               tcnt_d = {TW{1'b0}};
`endif
            end
         end
         S_HIGH: begin
            if (tcnt_q == high_end_s) begin
               tcnt_d  = {TW{1'b0}};
               state_d = S_LOW;
            end else begin
               state_d = S_HIGH;
            end
         end
         S_LOW: begin
            if (tcnt_q == low_end_s) begin
               tcnt_d = {TW{1'b0}};
               if (bit_q != 5'd0) begin
                  shift_d = {shift_q[22:0], 1'b0};
                  bit_d   = bit_q - 5'd1;
                  state_d = S_HIGH;
               end else if (pix_q < LAST_PIX) begin
                  pix_d   = pix_q + {{(PW-1){1'b0}}, 1'b1};
                  state_d = S_LOAD;
               end else begin
                  state_d = S_LATCH;
               end
            end else begin
               state_d = S_LOW;
            end
         end
         S_LATCH: begin
            if (tcnt_q == RST_END) begin
               tcnt_d       = {TW{1'b0}};
               frame_done_d = ~abort_q;
               state_d      = S_IDLE;
            end else begin
               state_d = S_LATCH;
            end
         end
         default: begin
            tcnt_d  = {TW{1'b0}};
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered copies of what the next state implies.
      dout_d      = (state_d == S_HIGH);
      pix_ready_d = (state_d == S_LOAD);
      busy_d      = (state_d != S_IDLE);
   end

   // State and output registers; reset drives the line low immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tcnt_q       <= {TW{1'b0}};
         shift_q      <= 24'd0;
         bit_q        <= 5'd0;
         pix_q        <= {PW{1'b0}};
         abort_q      <= 1'b0;
         dout_q       <= 1'b0;
         pix_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         pix_q        <= pix_d;
         abort_q      <= abort_d;
         dout_q       <= dout_d;
         pix_ready_q  <= pix_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign pix_if.pix_ready = pix_ready_q;
   assign busy             = busy_q;
   assign frame_done       = frame_done_q;
   assign underrun         = underrun_q;
   assign dout             = dout_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_ws2812_strip_driver
// Directed bench for ws2812_strip_driver (LED_NUM=2, 27 MHz defaults).
// A waveform-level model expands every accepted pixel into its expected dout
// levels and is compared against the DUT on every negative clock edge; a set
// of hand-computed pulse widths, periods and gaps pins the model.
// -----------------------------------------------------------------------------
module tb_ws2812_strip_driver;
   localparam int LED_NUM = 2;
   localparam int C0H = 10, C0L = 22, C1H = 22, C1L = 10, CRST = 2160;
`ifdef WS2812_UNDERRUN_EN
   localparam bit UR_EN = 1'b1;
`else
   localparam bit UR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, frame_done, underrun, dout;

   ws2812_strip_driver_if pif();

   ws2812_strip_driver #(
      .CLK_FRE(27_000_000), .LED_NUM(LED_NUM), .T0H_NS(400), .T0L_NS(850),
      .T1H_NS(850), .T1L_NS(400), .RESET_US(80)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix_if(pif),
      .busy(busy), .frame_done(frame_done), .underrun(underrun), .dout(dout)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 waiting for pixel, 2 playing waveform, 3 latch
   int m_mode = 0, m_pix = 0, m_wait = 0, m_lat = 0;
   bit m_abort = 1'b0;
   bit wave_q[$];
   bit e_dout = 1'b0, e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_under = 1'b0;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_mode = 0; wave_q.delete(); m_abort = 1'b0;
         e_dout = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_under = 1'b0;
      end else begin
         e_done = 1'b0; e_under = 1'b0; e_dout = 1'b0;
         case (m_mode)
            0: if (start) begin m_mode = 1; m_pix = 0; m_wait = 0; m_abort = 1'b0; end
            1: if (pif.pix_valid) begin
                  for (int b = 23; b >= 0; b--) begin
                     repeat (pif.pix_data[b] ? C1H : C0H) wave_q.push_back(1'b1);
                     repeat (pif.pix_data[b] ? C1L : C0L) wave_q.push_back(1'b0);
                  end
                  m_mode = 2;
               end else if (UR_EN && m_pix >= 1) begin
                  m_wait++;
                  if (m_wait == CRST / 2) begin
                     m_mode = 3; m_lat = CRST - 1; e_under = 1'b1; m_abort = 1'b1;
                  end
               end
            2: if (wave_q.size() == 0) begin
                  if (m_pix < LED_NUM - 1) begin m_pix++; m_mode = 1; m_wait = 0; end
                  else begin m_mode = 3; m_lat = CRST - 1; end
               end
            3: if (m_lat == 0) begin m_mode = 0; e_done = !m_abort; end
               else m_lat--;
            default: m_mode = 0;
         endcase
         if (m_mode == 2) e_dout = wave_q.pop_front();
         e_ready = (m_mode == 1);
         e_busy  = (m_mode != 0);
      end
   end

   // Per-cycle compare against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("cyc_dout",       32'(dout),          32'(e_dout));
         chk("cyc_pix_ready",  32'(pif.pix_ready), 32'(e_ready));
         chk("cyc_busy",       32'(busy),          32'(e_busy));
         chk("cyc_frame_done", 32'(frame_done),    32'(e_done));
         chk("cyc_underrun",   32'(underrun),      32'(e_under));
      end
   end

   // ---------------- measurement of the line ----------------
   int cyc = 0, hi = 0, fall_cyc = 0, done_gap = 0, done_cnt = 0, under_cnt = 0;
   int widths[$];
   int rises[$];
   logic prev = 1'b0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (dout === 1'b1 && prev !== 1'b1) begin rises.push_back(cyc); hi = 1; end
      else if (dout === 1'b1) hi++;
      if (dout !== 1'b1 && prev === 1'b1) begin widths.push_back(hi); fall_cyc = cyc; end
      if (frame_done === 1'b1) begin done_cnt++; done_gap = cyc - fall_cyc; end
      if (underrun === 1'b1) under_cnt++;
      prev = dout;
   end

   // ---------------- pixel source ----------------
   int hs_cnt = 0, hs_base = 0;
   logic [23:0] plist [2];

   initial forever begin
      @(posedge clk);
      if (rst_n && pif.pix_valid && pif.pix_ready) hs_cnt++;
   end

   initial begin
      pif.pix_data = 24'h000000;
      forever begin
         @(negedge clk);
         if ((hs_cnt - hs_base) >= 0 && (hs_cnt - hs_base) < 2)
            pif.pix_data = plist[hs_cnt - hs_base];
         else
            pif.pix_data = 24'h000000;
      end
   end

   function automatic bit cond(input int sel, input int tgt);
      case (sel)
         0:       return busy === 1'b0;
         1:       return pif.pix_ready === 1'b1;
         2:       return dout === 1'b1;
         3:       return (hs_cnt - hs_base) >= tgt;
         default: return widths.size() >= tgt;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int tgt, input int budget, input string nm);
      int n = 0;
      while (!cond(sel, tgt) && n < budget) begin @(negedge clk); n++; end
      if (!cond(sel, tgt)) begin
         n_checks++; n_fail++;
         $display("FAIL %s: wait timed out after %0d cycles", nm, n);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic new_frame(input logic [23:0] p0, input logic [23:0] p1);
      plist[0] = p0; plist[1] = p1; hs_base = hs_cnt;
   endtask

   initial begin : watchdog
      #600_000;
      n_fail++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   int wb, rb, dc, uc;

   initial begin
      pif.pix_valid = 1'b0;
      plist[0] = 24'h0; plist[1] = 24'h0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(pif.pix_ready), 32'd0);

      // Reset in the middle of a high phase.
      new_frame(24'h000000, 24'h000000);
      pif.pix_valid = 1'b1;
      wb = widths.size();
      pulse_start();
      wait_for(4, wb + 1, 200, "t1_first_pulse");
      wait_for(2, 0, 100, "t1_dout_high");
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(pif.pix_ready), 32'd0);
      chk("midrst_done", 32'(frame_done), 32'd0);
      chk("midrst_underrun", 32'(underrun), 32'd0);
      pif.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Fresh frame of zero pixels after reset.
      new_frame(24'h000000, 24'h000000);
      pif.pix_valid = 1'b1;
      wb = widths.size(); dc = done_cnt;
      pulse_start();
      wait_for(4, wb + 1, 200, "t1b_first_pulse");
      chk("t1b_first_high", widths[wb], 32'd10);
      wait_for(0, 0, 5000, "t1b_frame_end");
      chk("t1b_done_count", done_cnt - dc, 32'd1);

      // Two-pixel frame, valid always high, ignored mid-frame start.
      new_frame(24'hA50FC3, 24'h800001);
      wb = widths.size(); rb = rises.size(); dc = done_cnt;
      pulse_start();
      wait_for(4, wb + 5, 400, "t2_pulses_5");
      pulse_start();
      wait_for(0, 0, 5000, "t2_frame_end");
      pif.pix_valid = 1'b0;
      repeat (60) @(negedge clk);
      chk("t2_pulse_count", widths.size() - wb, 32'd48);
      chk("t2_w0", widths[wb], 32'd22);
      chk("t2_w1", widths[wb + 1], 32'd10);
      chk("t2_w2", widths[wb + 2], 32'd22);
      chk("t2_w23", widths[wb + 23], 32'd22);
      chk("t2_w24", widths[wb + 24], 32'd22);
      chk("t2_w25", widths[wb + 25], 32'd10);
      chk("t2_w47", widths[wb + 47], 32'd22);
      chk("t2_bit_period", rises[rb + 1] - rises[rb], 32'd32);
      chk("t2_pixel_gap", rises[rb + 24] - rises[rb + 23], 32'd33);
      chk("t2_latch_low", done_gap, 32'd2170);
      chk("t2_done_count", done_cnt - dc, 32'd1);
      chk("t2_idle_busy", 32'(busy), 32'd0);

      // Back-pressure: pixel 2 withheld for 5 cycles of LOAD.
      new_frame(24'hA50FC3, 24'h5A5A5A);
      pif.pix_valid = 1'b1;
      wb = widths.size(); rb = rises.size(); dc = done_cnt;
      pulse_start();
      wait_for(3, 1, 100, "t3_first_hs");
      pif.pix_valid = 1'b0;
      wait_for(1, 0, 1000, "t3_ready");
      repeat (5) @(negedge clk);
      pif.pix_valid = 1'b1;
      wait_for(0, 0, 5000, "t3_frame_end");
      pif.pix_valid = 1'b0;
      chk("t3_pulse_count", widths.size() - wb, 32'd48);
      chk("t3_pixel_gap", rises[rb + 24] - rises[rb + 23], 32'd38);
      chk("t3_done_count", done_cnt - dc, 32'd1);

      // Starvation: pixel 2 withheld for 1080 cycles.
      new_frame(24'h00FF00, 24'hFF00FF);
      pif.pix_valid = 1'b1;
      wb = widths.size(); dc = done_cnt; uc = under_cnt;
      pulse_start();
      wait_for(3, 1, 100, "t4_first_hs");
      pif.pix_valid = 1'b0;
      wait_for(1, 0, 1000, "t4_ready");
      repeat (1080) @(negedge clk);
      pif.pix_valid = 1'b1;
      wait_for(0, 0, 6000, "t4_frame_end");
      pif.pix_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("t4_underrun_count", under_cnt - uc, UR_EN ? 32'd1 : 32'd0);
      chk("t4_done_count", done_cnt - dc, UR_EN ? 32'd0 : 32'd1);
      chk("t4_pulse_count", widths.size() - wb, UR_EN ? 32'd24 : 32'd48);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
